button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes the clean, debounced active-high push-button level and turns it into single-cycle user events on the system clock: press, release, long-press and auto-repeat while held.
- Sits between each button debouncer and the clock's time-setting control logic, which uses these events to step and fast-advance hours and minutes.
- Its input is produced on a divided clock, so it is treated as asynchronous and synchronised here.

Parameters:
- TICK_DIV, 16, clk cycles per hold-timing tick; must be >= 2.
- LONG_TICKS, 8, ticks held after press before long_press fires; must be >= 1.
- REPEAT_TICKS, 4, ticks between successive repeat pulses after long_press; must be >= 1.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pb_in  input  1  debounced button level, 1 = pressed, asynchronous to clk.
- press  output  1  one-cycle pulse on press detection.
- release  output  1  one-cycle pulse on release detection.
- long_press  output  1  one-cycle pulse when hold reaches LONG_TICKS.
- repeat  output  1  one-cycle pulse every REPEAT_TICKS while held after long_press.
- held  output  1  level, 1 while state is PRESSED or LONG.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). While rst is high at a rising edge, all flops clear: sync stages 0, state IDLE, prescaler 0, hold counter 0. All outputs read 0. No release pulse is generated by reset.
- All outputs are registered.
- Synchroniser:
  - Two-flop chain, pb_in -> s1 -> pb_s.
  - pb_s reflects pb_in after 2 edges.
- State machine: IDLE, PRESSED, LONG.
- IDLE:
  - If pb_s=1: next state PRESSED, press=1 for one cycle, held=1, prescaler=0, hold counter=0.
  - press is therefore high in the cycle after the 3rd edge that samples pb_in=1.
- Tick:
  - The prescaler counts 0..TICK_DIV-1 only in PRESSED/LONG, then wraps.
  - tick is asserted internally in the cycle where prescaler = TICK_DIV-1.
  - The prescaler is held at 0 in IDLE.
- PRESSED:
  - pb_s=0 has highest priority: release=1, held=0, go to IDLE, and ignore any tick in that cycle.
  - Else on tick: if hold counter = LONG_TICKS-1, long_press=1, go to LONG, hold counter=0; otherwise increment the hold counter.
- LONG:
  - pb_s=0: release=1, held=0, go to IDLE (priority over tick).
  - Else on tick: if hold counter = REPEAT_TICKS-1, repeat=1, hold counter=0; otherwise increment.
- Timing from the press pulse cycle P, with pb_in held:
  - long_press at P + LONG_TICKS*TICK_DIV.
  - repeat at P + (LONG_TICKS + k*REPEAT_TICKS)*TICK_DIV, for k = 1, 2, ...
- Release latency: release is high in the cycle after the 3rd edge that samples pb_in=0.
- Mutual exclusion: at most one of press, release, long_press, repeat is high in any cycle.
- Reset mid-hold: all state is lost. If pb_in is still 1 after rst deasserts, a fresh press is generated 3 edges later and hold timing restarts.
- Glitch: a single-cycle pb_in high that reaches pb_s yields press followed by release exactly one cycle later; no long_press.

Test Plan (defaults: TICK_DIV=16, LONG_TICKS=8, REPEAT_TICKS=4):
1. Reset: rst=1 for 3 cycles with pb_in=1 -> all outputs 0 throughout. Deassert rst -> press pulses in the cycle after the 3rd edge, and held=1.
2. Short press: pb_in=1 for 50 cycles, then 0 -> exactly one press and one release (release 3 edges after the fall). long_press and repeat stay 0; held is high from press until release.
3. Long hold: pb_in=1 for 300 cycles after press (cycle P) -> long_press at P+128; repeat at P+192 and P+256; no other pulses until release.
4. Boundary: pb_s drops in the exact cycle the 8th tick would fire -> release only, long_press never asserts, state returns to IDLE.
5. Glitch: pb_in=1 for 1 cycle -> press, then release the next cycle; held high for 1 cycle; no long_press or repeat.
6. Reset mid-LONG at P+200 with pb_in held -> all outputs 0 with no release pulse. After rst deasserts, a new press occurs 3 edges later and long_press follows 128 cycles after that.

Source files
------------

// File: rtl/button_event.sv
// Button event generator: turns a debounced push-button level into
// single-cycle press / release / long-press / auto-repeat events.
module button_event #(
    parameter int TICK_DIV     = 16,
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_in,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic s1;
    logic pb_s;

    state_t state;
    state_t state_nxt;

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;

    logic tick;

    logic press_nxt;
    logic release_nxt;
    logic long_nxt;
    logic repeat_nxt;
    logic held_nxt;

    // pb_in comes from a divided clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            pb_s <= 1'b0;
        end else begin
            s1   <= pb_in;
            pb_s <= s1;
        end
    end

    assign tick = (state != IDLE) && (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pre      <= pre_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        unique case (state)
            IDLE: begin
                hold_nxt = '0;
                if (pb_s) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (!pb_s) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end else if (tick) begin
                    if (hold_cnt == LONG_LAST) begin
                        state_nxt = LONG;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            LONG: begin
                if (!pb_s) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end else if (tick) begin
                    if (hold_cnt == REP_LAST) begin
                        hold_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // Prescaler runs only while the button is held and restarts each press
    always_comb begin
        pre_nxt = '0;
        if (state != IDLE && state_nxt != IDLE) begin
            if (tick) begin
                pre_nxt = '0;
            end else begin
                pre_nxt = pre + 1'b1;
            end
        end
    end

    always_comb begin
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        held_nxt    = (state_nxt != IDLE);
        unique case (state)
            IDLE: begin
                press_nxt = pb_s;
            end
            PRESSED: begin
                release_nxt = !pb_s;
                long_nxt    = pb_s && tick
                              && (hold_cnt == LONG_LAST);
            end
            LONG: begin
                release_nxt = !pb_s;
                repeat_nxt  = pb_s && tick
                              && (hold_cnt == REP_LAST);
            end
            default: begin
                held_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press         <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
            held          <= held_nxt;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: stimulus queues expected
// events, a negedge monitor pops and compares them.
module tb_button_event;

    localparam int LONG_CYC = 8 * 16;
    localparam int REP_CYC  = 4 * 16;

    logic clk = 1'b0;
    logic rst;
    logic pb_in;
    logic press;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;
    logic held;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        int p;
        int r;
    } win_t;

    ev_t  q[$];
    win_t wq[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    string kname [4] = '{"press", "release", "long_press", "repeat"};

    button_event dut (
        .clk           (clk),
        .rst           (rst),
        .pb_in         (pb_in),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int   npulse;
    int   okind;
    logic exp_h;
    ev_t  e;

    always @(negedge clk) begin
        if (cyc > 0) begin
            npulse = int'(press) + int'(release_pulse)
                   + int'(long_press) + int'(repeat_pulse);
            exp_h = 1'b0;
            if (wq.size() > 0) begin
                exp_h = (cyc >= wq[0].p) && (cyc < wq[0].r);
            end
            compared++;
            if (held !== exp_h) begin
                mismatched++;
                $display("FAIL held cyc=%0d got=%b exp=%b",
                         cyc, held, exp_h);
            end
            if (wq.size() > 0 && cyc + 1 >= wq[0].r) begin
                void'(wq.pop_front());
            end
            if (rst) begin
                compared++;
                if (npulse != 0) begin
                    mismatched++;
                    $display("FAIL reset_quiet cyc=%0d pulses=%0d exp=0",
                             cyc, npulse);
                end
            end
            if (npulse > 0) begin
                compared++;
                if (npulse != 1) begin
                    mismatched++;
                    $display("FAIL mutex cyc=%0d pulses=%0d exp=1",
                             cyc, npulse);
                end
                okind = press ? 0 : release_pulse ? 1
                      : long_press ? 2 : 3;
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected cyc=%0d got=%s exp=none",
                             cyc, kname[okind]);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.kind != okind) begin
                        mismatched++;
                        $display("FAIL event got=%s@%0d exp=%s@%0d",
                                 kname[okind], cyc,
                                 kname[e.kind], e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int k);
        ev_t x;
        x.cyc  = c;
        x.kind = k;
        q.push_back(x);
    endtask

    task automatic push_win(input int p, input int r);
        win_t w;
        w.p = p;
        w.r = r;
        wq.push_back(w);
    endtask

    // Hold pb_in high for n cycles from now, then let it fall
    task automatic run_hold(input int n);
        int c0;
        int p;
        int r;
        c0 = cyc;
        p  = c0 + 3;
        r  = c0 + n + 3;
        pb_in = 1'b1;
        push(p, 0);
        if (p + LONG_CYC < r) push(p + LONG_CYC, 2);
        for (int t = p + LONG_CYC + REP_CYC; t < r; t += REP_CYC) begin
            push(t, 3);
        end
        push(r, 1);
        push_win(p, r);
        wait_cyc(n);
        pb_in = 1'b0;
        wait_cyc(10);
    endtask

    initial begin
        int c0;
        int p;
        rst   = 1'b1;
        pb_in = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        run_hold(40);

        run_hold(50);
        run_hold(303);
        run_hold(128);
        run_hold(192);
        run_hold(1);

        c0 = cyc;
        p  = c0 + 3;
        pb_in = 1'b1;
        push(p, 0);
        push(p + LONG_CYC, 2);
        push(p + LONG_CYC + REP_CYC, 3);
        push_win(p, p + 201);
        wait_cyc(203);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        run_hold(140);

        wait_cyc(10);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_events got=%0d exp=0 next=%s@%0d",
                     q.size(), kname[q[0].kind], q[0].cyc);
        end
        compared++;
        if (wq.size() != 0) begin
            mismatched++;
            $display("FAIL pending_windows got=%0d exp=0", wq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
